// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU execution unit: operation codes
// from the VALU control decoder and the sequencer state encoding.
package valu_pkg;

  localparam logic [2:0] VALU_SMUL = 3'b000;
  localparam logic [2:0] VALU_DOT  = 3'b001;
  localparam logic [2:0] VALU_ADD  = 3'b010;
  localparam logic [2:0] VALU_SUB  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } valu_state_e;

endpackage

// File: rtl/valu_lane.sv
// Single-element arithmetic for the vector ALU: add, sub and multiply
// (low SEW bits). Unknown codes produce zero.
// Build option: VALU_EXEC_SAT_EN makes add/sub saturate as signed SEW-bit values.
module valu_lane
  import valu_pkg::*;
#(
  parameter int SEW = 32
) (
  input  logic [2:0]     op_i,
  input  logic [SEW-1:0] a_i,
  input  logic [SEW-1:0] b_i,
  output logic [SEW-1:0] y_o
);

  // Clamp a one-bit-extended signed sum to the SEW-bit signed range.
  function automatic logic [SEW-1:0] sat_sum(input logic signed [SEW:0] wide);
    logic [SEW-1:0] res;
    if (wide[SEW] != wide[SEW-1]) begin
      res = wide[SEW] ? {1'b1, {(SEW-1){1'b0}}} : {1'b0, {(SEW-1){1'b1}}};
    end else begin
      res = wide[SEW-1:0];
    end
    return res;
  endfunction

  logic signed [SEW-1:0] a_s;
  logic signed [SEW-1:0] b_s;
  logic signed [SEW:0]   add_wide;
  logic signed [SEW:0]   sub_wide;
  logic [SEW-1:0]        add_res;
  logic [SEW-1:0]        sub_res;
  logic [SEW-1:0]        mul_res;

  assign a_s      = a_i;
  assign b_s      = b_i;
  assign add_wide = {a_s[SEW-1], a_s} + {b_s[SEW-1], b_s};
  assign sub_wide = {a_s[SEW-1], a_s} - {b_s[SEW-1], b_s};
  assign mul_res  = a_i * b_i;

`ifdef VALU_EXEC_SAT_EN
  assign add_res = sat_sum(add_wide);
  assign sub_res = sat_sum(sub_wide);
`else
  assign add_res = add_wide[SEW-1:0];
  assign sub_res = sub_wide[SEW-1:0];
`endif

  // Select the lane result for the requested operation.
  always_comb begin
    y_o = '0;
    case (op_i)
      VALU_ADD:  y_o = add_res;
      VALU_SUB:  y_o = sub_res;
      VALU_SMUL: y_o = mul_res;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/valu_exec.sv
// Vector ALU execution unit: accepts one vector operation, processes one
// element per cycle through a shared lane, then holds the result until the
// consumer takes it. Dot product accumulates lane products into element 0.
// Build option: VALU_EXEC_SAT_EN (saturating add/sub, handled in valu_lane).
module valu_exec
  import valu_pkg::*;
#(
  parameter int NUM_ELEM = 4,
  parameter int SEW      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [2:0]              valu_ctrl_i,
  input  logic [NUM_ELEM*SEW-1:0] vs1_i,
  input  logic [NUM_ELEM*SEW-1:0] vs2_i,
  input  logic [SEW-1:0]          rs1_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [NUM_ELEM*SEW-1:0] vd_o
);

  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEM - 1);

  valu_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [SEW-1:0]          acc_q;
  logic [NUM_ELEM*SEW-1:0] vd_q;

  logic [2:0]              op_q;
  logic [NUM_ELEM*SEW-1:0] vs1_q;
  logic [NUM_ELEM*SEW-1:0] vs2_q;
  logic [SEW-1:0]          rs1_q;

  logic                    accept;
  logic                    last_elem;
  logic [2:0]              lane_op;
  logic [SEW-1:0]          lane_a;
  logic [SEW-1:0]          lane_b;
  logic [SEW-1:0]          lane_y;
  logic [SEW-1:0]          acc_sum;

  assign accept    = (state_q == ST_IDLE) && valid_i;
  assign last_elem = (idx_q == IDX_LAST);
  assign acc_sum   = acc_q + lane_y;
  assign vd_o      = vd_q;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_elem) state_d = ST_DONE;
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture at acceptance; later input changes cannot affect the result.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q  <= valu_ctrl_i;
      vs1_q <= vs1_i;
      vs2_q <= vs2_i;
      rs1_q <= rs1_i;
    end
  end

  // Route the current element to the lane; dot product reuses the multiplier.
  always_comb begin
    lane_op = op_q;
    lane_a  = vs1_q[int'(idx_q)*SEW +: SEW];
    lane_b  = vs2_q[int'(idx_q)*SEW +: SEW];
    case (op_q)
      VALU_SMUL: begin
        lane_a = vs2_q[int'(idx_q)*SEW +: SEW];
        lane_b = rs1_q;
      end
      VALU_DOT: lane_op = VALU_SMUL;
      default: ;
    endcase
  end

  valu_lane #(.SEW(SEW)) u_lane (
    .op_i (lane_op),
    .a_i  (lane_a),
    .b_i  (lane_b),
    .y_o  (lane_y)
  );

  // Element index, dot accumulator and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      acc_q <= '0;
      vd_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            idx_q <= '0;
            acc_q <= '0;
            vd_q  <= '0;
          end
        end
        ST_RUN: begin
          idx_q <= last_elem ? '0 : idx_q + 1'b1;
          if (op_q == VALU_DOT) begin
            acc_q <= acc_sum;
            if (last_elem) vd_q[SEW-1:0] <= acc_sum;
          end else begin
            vd_q[int'(idx_q)*SEW +: SEW] <= lane_y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_valu_exec.sv
// Randomized self-checking bench for valu_exec (NUM_ELEM=4, SEW=32) with a
// behavioural reference model, plus directed vectors and reset/backpressure cases.
module tb_valu_exec;

  localparam int NE = 4;
  localparam int SW = 32;
  localparam int VW = NE * SW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [2:0]    valu_ctrl_i = '0;
  logic [VW-1:0] vs1_i = '0;
  logic [VW-1:0] vs2_i = '0;
  logic [SW-1:0] rs1_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [VW-1:0] vd_o;

  int checks = 0;
  int errors = 0;

  valu_exec #(.NUM_ELEM(NE), .SEW(SW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .valu_ctrl_i (valu_ctrl_i),
    .vs1_i       (vs1_i),
    .vs2_i       (vs2_i),
    .rs1_i       (rs1_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .vd_o        (vd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] addsub_ref(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                               input bit is_sub);
    longint s;
    s = is_sub ? (longint'($signed(a)) - longint'($signed(b)))
               : (longint'($signed(a)) + longint'($signed(b)));
`ifdef VALU_EXEC_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[SW-1:0];
  endfunction

  // Reference: the operation applied to whole vectors with plain arithmetic.
  function automatic logic [VW-1:0] model(input logic [2:0] ctrl, input logic [VW-1:0] v1,
                                          input logic [VW-1:0] v2, input logic [SW-1:0] s);
    logic [VW-1:0] r;
    logic [SW-1:0] a, b;
    longint unsigned acc;
    r = '0;
    acc = 0;
    for (int i = 0; i < NE; i++) begin
      a = v1[i*SW +: SW];
      b = v2[i*SW +: SW];
      case (ctrl)
        3'b010: r[i*SW +: SW] = addsub_ref(a, b, 1'b0);
        3'b110: r[i*SW +: SW] = addsub_ref(a, b, 1'b1);
        3'b000: r[i*SW +: SW] = SW'((longint'(b) * longint'(s)) % 64'd4294967296);
        3'b001: acc = (acc + longint'(a) * longint'(b)) % 64'd4294967296;
        default: ;
      endcase
    end
    if (ctrl == 3'b001) r[SW-1:0] = acc[SW-1:0];
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [VW-1:0] v1,
                        input logic [VW-1:0] v2, input logic [SW-1:0] s, input int hold,
                        input logic [VW-1:0] exp);
    int n;
    valid_i = 1'b1; valu_ctrl_i = ctrl; vs1_i = v1; vs2_i = v2; rs1_i = s;
    check({tag, ".ready_idle"}, VW'(ready_o), VW'(1));
    @(posedge clk); #1;
    valid_i = 1'b0;
    valu_ctrl_i = 3'($urandom); vs1_i = {$urandom, $urandom, $urandom, $urandom};
    vs2_i = {$urandom, $urandom, $urandom, $urandom}; rs1_i = $urandom;
    check({tag, ".ready_run"}, VW'(ready_o), VW'(0));
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
      valid_i = (n == 1);
    end
    valid_i = 1'b0;
    check({tag, ".latency"}, VW'(n), VW'(NE));
    check({tag, ".vd"}, vd_o, exp);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      check({tag, ".hold_valid"}, VW'(valid_o), VW'(1));
      check({tag, ".hold_ready"}, VW'(ready_o), VW'(0));
      check({tag, ".hold_vd"}, vd_o, exp);
      if (k == 0) valid_i = 1'b1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check({tag, ".ret_ready"}, VW'(ready_o), VW'(1));
    check({tag, ".ret_valid"}, VW'(valid_o), VW'(0));
    check({tag, ".retain_vd"}, vd_o, exp);
  endtask

  initial begin
    logic [VW-1:0] v1, v2, e;
    logic [SW-1:0] s;
    logic [2:0]    c;

    #12;
    check("rst.ready", VW'(ready_o), VW'(1));
    check("rst.valid", VW'(valid_o), VW'(0));
    check("rst.vd", vd_o, '0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    run_op("add", 3'b010, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
           32'd0, 5, {32'd44, 32'd33, 32'd22, 32'd11});
    run_op("dot", 3'b001, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8},
           32'd0, 0, {32'd0, 32'd0, 32'd0, 32'd70});
    run_op("smul", 3'b000, '0, {32'd1, 32'd2, 32'd3, 32'd4}, 32'd3, 1,
           {32'd3, 32'd6, 32'd9, 32'd12});
`ifdef VALU_EXEC_SAT_EN
    e = {32'd0, 32'd0, 32'd0, 32'h8000_0000};
`else
    e = {32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF};
`endif
    run_op("sub_bnd", 3'b110, {32'd0, 32'd0, 32'd0, 32'h8000_0000}, {32'd0, 32'd0, 32'd0, 32'd1},
           32'd0, 0, e);
    run_op("bad_op", 3'b111, {32'd9, 32'd9, 32'd9, 32'd9}, {32'd9, 32'd9, 32'd9, 32'd9},
           32'd9, 0, '0);

    // Reset in the middle of an operation, at element index 2.
    valid_i = 1'b1; valu_ctrl_i = 3'b010;
    vs1_i = {32'd1, 32'd1, 32'd1, 32'd1}; vs2_i = {32'd1, 32'd1, 32'd1, 32'd1};
    @(posedge clk); #1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    #1;
    check("midrst.ready", VW'(ready_o), VW'(1));
    check("midrst.valid", VW'(valid_o), VW'(0));
    check("midrst.vd", vd_o, '0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("midrst.no_result", VW'(valid_o), VW'(0));
    run_op("after_rst", 3'b010, {32'd7, 32'd6, 32'd5, 32'd4}, {32'd1, 32'd1, 32'd1, 32'd1},
           32'd0, 0, {32'd8, 32'd7, 32'd6, 32'd5});

    for (int t = 0; t < 16; t++) begin
      c  = 3'($urandom);
      if (t < 8) c = (t % 2 == 0) ? 3'b010 : 3'b110;
      v1 = {$urandom, $urandom, $urandom, $urandom};
      v2 = {$urandom, $urandom, $urandom, $urandom};
      if (t % 4 == 1) begin
        v1[31:0] = 32'h7FFF_FFF0;
        v2[31:0] = (c == 3'b110) ? 32'hFFFF_FFF0 : 32'h0000_0100;
      end
      s  = $urandom;
      e  = model(c, v1, v2, s);
      run_op("rand", c, v1, v2, s, int'($urandom_range(0, 3)), e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/valu_exec.md
VALU_EXEC -- requirements
Module: valu_exec

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 4, giving the number of elements per vector.
REQ-002 SHALL have parameter SEW, default 32, giving the element width in bits.
REQ-003 Clock and reset: one clock, clk_i; reset rst_i is asynchronous, active-high.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 valid_i  input  1  operation request.
REQ-007 ready_o  output  1  unit can accept a request.
REQ-008 valu_ctrl_i  input  3  operation code from the VALU control decoder.
REQ-009 vs1_i  input  NUM_ELEM*SEW  operand vector 1; element i is at bits [i*SEW +: SEW].
REQ-010 vs2_i  input  NUM_ELEM*SEW  operand vector 2, packed the same way.
REQ-011 rs1_i  input  SEW  scalar operand.
REQ-012 valid_o  output  1  result available.
REQ-013 ready_i  input  1  consumer accepts the result.
REQ-014 vd_o  output  NUM_ELEM*SEW  result vector.

Function
REQ-015 Operation codes SHALL be:
- 010: vd[i] = vs1[i] + vs2[i].
- 110: vd[i] = vs1[i] - vs2[i].
- 000: vd[i] = vs2[i] * rs1, low SEW bits.
- 001: vd[0] = sum over i of vs1[i]*vs2[i], modulo 2^SEW; vd[1..] = 0.
REQ-016 Any other code SHALL produce vd = 0 with the normal latency.
REQ-017 The state machine SHALL have three states: IDLE, RUN, DONE.
REQ-018 In IDLE, ready_o=1; when valid_i=1 at a clock edge, the block latches valu_ctrl_i, vs1_i, vs2_i and rs1_i, clears the element index and the accumulator, and moves to RUN.
REQ-019 In RUN, the block processes exactly one element per cycle, at index idx, and increments idx.
REQ-020 On the edge that processes idx = NUM_ELEM-1, the block moves to DONE.
REQ-021 In DONE, valid_o=1 and vd_o is held stable; the block returns to IDLE on the first edge with ready_i=1.
REQ-022 ready_o SHALL be 0 in RUN and DONE; valid_i in those states is ignored and no operand is latched.
REQ-023 valid_o SHALL first be high NUM_ELEM cycles after the acceptance edge; minimum spacing between accepted requests is NUM_ELEM+2 cycles.
REQ-024 Latched operands SHALL make the result independent of input changes after acceptance.
REQ-025 Add, sub and mul SHALL wrap modulo 2^SEW (unless REQ-029 applies).
REQ-026 The dot-product accumulator SHALL be SEW bits wide and wrap.
REQ-027 vd_o SHALL retain the last result in IDLE until the next acceptance, which clears it.

Reset
REQ-028 While rst_i=1, the block SHALL be in IDLE with ready_o=1, valid_o=0, vd_o=0, idx=0 and accumulator=0; reset asserted mid-RUN or in DONE abandons the operation with no result emitted.

Configuration
REQ-029 Macro VALU_EXEC_SAT_EN, when defined, SHALL make add (010) and sub (110) saturate as signed SEW-bit values: clamp to 2^(SEW-1)-1 or -2^(SEW-1).
REQ-030 Without VALU_EXEC_SAT_EN, add and sub wrap; mul and dot product wrap in both builds.

Structure
REQ-031 Shared package valu_pkg SHALL hold:
- the operation-code constants (VALU_ADD=010, VALU_SUB=110, VALU_SMUL=000, VALU_DOT=001);
- the FSM state encoding.
REQ-032 Single-element arithmetic (add/sub/mul, with optional saturation) SHALL live in one combinational sub-module, valu_lane; the FSM, index, accumulator and result register stay in valu_exec.

Verification (SEW=32, NUM_ELEM=4)
REQ-033 add: vs1={4,3,2,1}, vs2={40,30,20,10}, ctrl=010 -> valid_o after 4 cycles, vd={44,33,22,11}.
REQ-034 dot: vs1={1,2,3,4}, vs2={5,6,7,8}, ctrl=001 -> vd={0,0,0,70}; scalar mul vs2={1,2,3,4}, rs1=3, ctrl=000 -> {3,6,9,12}.
REQ-035 sub boundary: vs1[0]=0x80000000, vs2[0]=1 -> vd[0]=0x7FFFFFFF without VALU_EXEC_SAT_EN, and 0x80000000 with it.
REQ-036 Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o stays 1, vd stable, ready_o=0; a valid_i pulse during RUN/DONE is ignored.
REQ-037 Reset: assert rst_i during RUN at idx=2 -> outputs return to reset values immediately; the next request completes correctly.
